// File: rtl/store_lane_queue.sv
// Store-lane unit: decodes M-stage stores into byte enables and lane-replicated data, then
// queues them toward the data-memory bus. Define STORE_EXC_EN to trap misaligned stores.
module store_lane_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned NB = DATA_W / 8,
    localparam int unsigned LB = $clog2(NB),
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       ir_m,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [NB-1:0]     out_be,
    output logic [DATA_W-1:0] out_wdata,
    output logic [CW-1:0]     count,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] exc_badvaddr
);

    localparam logic [5:0] OpSb = 6'b101000;
    localparam logic [5:0] OpSh = 6'b101001;
    localparam logic [5:0] OpSw = 6'b101011;
    localparam logic [5:0] OpSd = 6'b111111;

    logic [5:0]        op;
    logic [LB-1:0]     ofs;
    logic              is_sb, is_sh, is_sw, is_sd, is_store;
    logic              misaligned;
    logic              accept, enq, pop;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] rep;
    logic [ADDR_W-1:0] aligned_addr;
    logic              unused_ir;

    assign op        = ir_m[31:26];
    assign unused_ir = ^ir_m[25:0];
    assign ofs       = addr[LB-1:0];

    assign is_sb    = (op == OpSb);
    assign is_sh    = (op == OpSh);
    assign is_sw    = (op == OpSw);
    assign is_sd    = (op == OpSd) && (DATA_W == 64);
    assign is_store = is_sb || is_sh || is_sw || is_sd;

`ifdef STORE_EXC_EN
    assign misaligned = (is_sh && ofs[0]) || (is_sw && (ofs[1:0] != 2'b00)) ||
                        (is_sd && (ofs != '0));
`else
    assign misaligned = 1'b0;
`endif

    // Clearing the low offset bits truncates misaligned sh/sw to their natural lane group.
    always_comb begin
        be = '0;
        if (is_sb) begin
            be = NB'(1) << ofs;
        end else if (is_sh) begin
            be = NB'(3) << (ofs & ~LB'(1));
        end else if (is_sw) begin
            be = NB'(15) << (ofs & ~LB'(3));
        end else if (is_sd) begin
            be = '1;
        end
    end

    always_comb begin
        rep = wdata;
        if (is_sb) begin
            for (int unsigned i = 0; i < NB; i++) rep[8*i +: 8] = wdata[7:0];
        end else if (is_sh) begin
            for (int unsigned i = 0; i < NB / 2; i++) rep[16*i +: 16] = wdata[15:0];
        end else if (is_sw) begin
            for (int unsigned i = 0; i < NB / 4; i++) rep[32*i +: 32] = wdata[31:0];
        end
    end

    assign aligned_addr = addr & ~ADDR_W'(NB - 1);

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign enq       = accept && is_store && !misaligned;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [NB-1:0]     mem_be   [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_addr[wr_q] <= aligned_addr;
            mem_be[wr_q]   <= be;
            mem_data[wr_q] <= rep;
        end
    end

    always_comb begin
        wr_d    = enq ? wr_q + PW'(1) : wr_q;
        rd_d    = pop ? rd_q + PW'(1) : rd_q;
        count_d = count_q;
        if (enq && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!enq && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Empty queue drives zeros rather than whatever stale entry the read pointer sits on.
    assign out_addr  = out_valid ? mem_addr[rd_q] : '0;
    assign out_be    = out_valid ? mem_be[rd_q]   : '0;
    assign out_wdata = out_valid ? mem_data[rd_q] : '0;

`ifdef STORE_EXC_EN
    logic              exc_ades_q;
    logic [ADDR_W-1:0] exc_badvaddr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_ades_q     <= 1'b0;
            exc_badvaddr_q <= '0;
        end else begin
            exc_ades_q <= accept && misaligned;
            if (accept && misaligned) begin
                exc_badvaddr_q <= addr;
            end
        end
    end

    assign exc_ades     = exc_ades_q;
    assign exc_badvaddr = exc_badvaddr_q;
`else
    assign exc_ades     = 1'b0;
    assign exc_badvaddr = '0;
`endif

endmodule

// File: tb/tb_store_lane_queue.sv
// Bench for store_lane_queue: a 32-bit/depth-2 and a 64-bit/depth-4 instance share stimulus
// and are each compared against a queue-based reference model.
module tb_store_lane_queue;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SD = 6'b111111;
    localparam logic [5:0] OP_LW = 6'b100011;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] ir_m;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        out_ready;

    logic        in_ready32, out_valid32, exc_ades32;
    logic [31:0] out_addr32, out_wdata32, exc_badvaddr32;
    logic [3:0]  out_be32;
    logic [1:0]  count32;

    logic        in_ready64, out_valid64, exc_ades64;
    logic [31:0] out_addr64, exc_badvaddr64;
    logic [63:0] out_wdata64;
    logic [7:0]  out_be64;
    logic [2:0]  count64;

    int checks = 0;
    int errors = 0;

    store_lane_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(2)) dut32 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
        .ir_m(ir_m), .addr(addr), .wdata(wdata[31:0]), .out_valid(out_valid32),
        .out_ready(out_ready), .out_addr(out_addr32), .out_be(out_be32),
        .out_wdata(out_wdata32), .count(count32), .exc_ades(exc_ades32),
        .exc_badvaddr(exc_badvaddr32)
    );

    store_lane_queue #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
        .ir_m(ir_m), .addr(addr), .wdata(wdata), .out_valid(out_valid64),
        .out_ready(out_ready), .out_addr(out_addr64), .out_be(out_be64),
        .out_wdata(out_wdata64), .count(count64), .exc_ades(exc_ades64),
        .exc_badvaddr(exc_badvaddr64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
        logic        keep;
        logic        fault;
    } ent_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [63:0] wd;
        logic        v32;
        logic [3:0]  be32;
        logic [31:0] wd32;
        logic [31:0] a32;
        logic        v64;
        logic [7:0]  be64;
        logic [63:0] wd64;
        logic [31:0] a64;
    } vec_t;

    ent_t        q32[$];
    ent_t        q64[$];
    logic        ades32_m, ades64_m;
    logic [31:0] bad32_m, bad64_m;

    // Reference: a store of sz bytes occupies lanes base..base+sz-1 and every lane i carries
    // data byte (i mod sz).
    function automatic ent_t model(input logic [5:0] op, input logic [31:0] a,
                                   input logic [63:0] wd, input int nb);
        ent_t e;
        int sz, o, base;
        e = '0;
        case (op)
            OP_SB:   sz = 1;
            OP_SH:   sz = 2;
            OP_SW:   sz = 4;
            OP_SD:   sz = (nb == 8) ? 8 : 0;
            default: sz = 0;
        endcase
        if (sz == 0) return e;
        o = int'(a[2:0]) % nb;
        base = (o / sz) * sz;
`ifdef STORE_EXC_EN
        if ((o % sz) != 0) begin
            e.fault = 1'b1;
            return e;
        end
`endif
        e.keep = 1'b1;
        e.addr = a - 32'(o);
        for (int i = 0; i < sz; i++) e.be[base + i] = 1'b1;
        for (int i = 0; i < nb; i++) e.data[8*i +: 8] = wd[8*(i % sz) +: 8];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_models();
        q32.delete();
        q64.delete();
        ades32_m = 1'b0;
        ades64_m = 1'b0;
        bad32_m  = '0;
        bad64_m  = '0;
    endtask

    // Compare both DUTs with the model at the falling edge, advance the model with the inputs
    // the DUTs will sample next, then return 1 time unit after the rising edge.
    task automatic cycle();
        ent_t h, e;
        bit   acc;
        @(negedge clk);
        h = (q32.size() != 0) ? q32[0] : '0;
        chk("in_ready32", 64'(in_ready32), 64'(q32.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q32.size() != 0));
        chk("count32", 64'(count32), 64'(q32.size()));
        chk("out_addr32", 64'(out_addr32), 64'(h.addr));
        chk("out_be32", 64'(out_be32), 64'(h.be));
        chk("out_wdata32", 64'(out_wdata32), h.data);
        chk("exc_ades32", 64'(exc_ades32), 64'(ades32_m));
        chk("exc_badvaddr32", 64'(exc_badvaddr32), 64'(bad32_m));
        h = (q64.size() != 0) ? q64[0] : '0;
        chk("in_ready64", 64'(in_ready64), 64'(q64.size() < 4));
        chk("out_valid64", 64'(out_valid64), 64'(q64.size() != 0));
        chk("count64", 64'(count64), 64'(q64.size()));
        chk("out_addr64", 64'(out_addr64), 64'(h.addr));
        chk("out_be64", 64'(out_be64), 64'(h.be));
        chk("out_wdata64", out_wdata64, h.data);
        chk("exc_ades64", 64'(exc_ades64), 64'(ades64_m));
        chk("exc_badvaddr64", 64'(exc_badvaddr64), 64'(bad64_m));

        acc = in_valid && (q32.size() < 2);
        e = model(ir_m[31:26], addr, {32'h0, wdata[31:0]}, 4);
        ades32_m = acc && e.fault;
        if (acc && e.fault) bad32_m = addr;
        if ((q32.size() != 0) && out_ready) void'(q32.pop_front());
        if (acc && e.keep) q32.push_back(e);

        acc = in_valid && (q64.size() < 4);
        e = model(ir_m[31:26], addr, wdata, 8);
        ades64_m = acc && e.fault;
        if (acc && e.fault) bad64_m = addr;
        if ((q64.size() != 0) && out_ready) void'(q64.pop_front());
        if (acc && e.keep) q64.push_back(e);

        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [63:0] wd);
        in_valid = 1'b1;
        ir_m     = {op, 26'($urandom)};
        addr     = a;
        wdata    = wd;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) cycle();
    endtask

    vec_t tbl[8];

    initial begin
        ent_t e32, e64;
        logic [5:0] op;

        tbl[0] = '{OP_SB, 32'h1003, 64'hAB, 1'b1, 4'h8, 32'hABABABAB, 32'h1000,
                   1'b1, 8'h08, 64'hABABABABABABABAB, 32'h1000};
        tbl[1] = '{OP_SW, 32'h2004, 64'h12345678, 1'b1, 4'hF, 32'h12345678, 32'h2004,
                   1'b1, 8'hF0, 64'h1234567812345678, 32'h2000};
        tbl[2] = '{OP_SH, 32'h11, 64'hBEEF, 1'b1, 4'h3, 32'hBEEFBEEF, 32'h10,
                   1'b1, 8'h03, 64'hBEEFBEEFBEEFBEEF, 32'h10};
        tbl[3] = '{OP_SH, 32'h16, 64'h1234, 1'b1, 4'hC, 32'h12341234, 32'h14,
                   1'b1, 8'hC0, 64'h1234123412341234, 32'h10};
        tbl[4] = '{OP_SD, 32'h38, 64'h0123456789ABCDEF, 1'b0, 4'h0, 32'h0, 32'h0,
                   1'b1, 8'hFF, 64'h0123456789ABCDEF, 32'h38};
        tbl[5] = '{OP_LW, 32'h40, 64'h99, 1'b0, 4'h0, 32'h0, 32'h0,
                   1'b0, 8'h00, 64'h0, 32'h0};
        tbl[6] = '{OP_SB, 32'h5, 64'hFFFFFFFFFFFFFF77, 1'b1, 4'h2, 32'h77777777, 32'h4,
                   1'b1, 8'h20, 64'h7777777777777777, 32'h0};
        tbl[7] = '{OP_SW, 32'h103, 64'h55555555CAFEF00D, 1'b1, 4'hF, 32'hCAFEF00D, 32'h100,
                   1'b1, 8'h0F, 64'hCAFEF00DCAFEF00D, 32'h100};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ir_m      = '0;
        addr      = '0;
        wdata     = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_count32", 64'(count32), 64'd0);
        chk("rst_valid32", 64'(out_valid32), 64'd0);
        chk("rst_ready32", 64'(in_ready32), 64'd1);
        chk("rst_ready64", 64'(in_ready64), 64'd1);
        cycle();

        // Single stores from an empty queue against fixed expectations.
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].op, tbl[k].a, tbl[k].wd);
            out_ready = 1'b1;
            e32 = model(tbl[k].op, tbl[k].a, tbl[k].wd, 4);
            e64 = model(tbl[k].op, tbl[k].a, tbl[k].wd, 8);
            cycle();
            in_valid  = 1'b0;
            out_ready = 1'b0;
            chk($sformatf("tv%0d_valid32", k), 64'(out_valid32), 64'(tbl[k].v32 && !e32.fault));
            chk($sformatf("tv%0d_valid64", k), 64'(out_valid64), 64'(tbl[k].v64 && !e64.fault));
            if (tbl[k].v32 && !e32.fault) begin
                chk($sformatf("tv%0d_be32", k), 64'(out_be32), 64'(tbl[k].be32));
                chk($sformatf("tv%0d_wd32", k), 64'(out_wdata32), 64'(tbl[k].wd32));
                chk($sformatf("tv%0d_addr32", k), 64'(out_addr32), 64'(tbl[k].a32));
            end
            if (tbl[k].v64 && !e64.fault) begin
                chk($sformatf("tv%0d_be64", k), 64'(out_be64), 64'(tbl[k].be64));
                chk($sformatf("tv%0d_wd64", k), out_wdata64, tbl[k].wd64);
                chk($sformatf("tv%0d_addr64", k), 64'(out_addr64), 64'(tbl[k].a64));
            end
            if (e32.fault) begin
                chk($sformatf("tv%0d_ades32", k), 64'(exc_ades32), 64'd1);
                chk($sformatf("tv%0d_bad32", k), 64'(exc_badvaddr32), 64'(tbl[k].a));
            end
            out_ready = 1'b1;
            cycle();
        end
        drain();

        // Fill the depth-2 queue with out_ready low; a third store must be refused.
        out_ready = 1'b0;
        drive(OP_SB, 32'h1, 64'h11);
        cycle();
        drive(OP_SB, 32'h2, 64'h22);
        cycle();
        chk("full_count32", 64'(count32), 64'd2);
        chk("full_ready32", 64'(in_ready32), 64'd0);
        drive(OP_SB, 32'h3, 64'h33);
        out_ready = 1'b1;
        cycle();
        chk("full_hold_count32", 64'(count32), 64'd1);
        chk("full_head2_be32", 64'(out_be32), 64'h4);
        chk("full_reopen32", 64'(in_ready32), 64'd1);
        in_valid = 1'b0;
        cycle();
        chk("full_empty32", 64'(out_valid32), 64'd0);
        drain();

        // Asynchronous reset with entries queued.
        out_ready = 1'b0;
        drive(OP_SW, 32'h80, 64'hDEADBEEF);
        cycle();
        drive(OP_SW, 32'h84, 64'hFEEDFACE);
        cycle();
        in_valid = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid32", 64'(out_valid32), 64'd0);
        chk("arst_count32", 64'(count32), 64'd0);
        chk("arst_be32", 64'(out_be32), 64'd0);
        chk("arst_valid64", 64'(out_valid64), 64'd0);
        chk("arst_wd64", out_wdata64, 64'd0);
        clear_models();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       op = OP_SB;
                1:       op = OP_SH;
                2:       op = OP_SW;
                3:       op = OP_SD;
                default: op = 6'($urandom);
            endcase
            drive(op, $urandom, {$urandom, $urandom});
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
